// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc_plus4;
    } fetch_bundle_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched bundle that arrived while decode was stalled.
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  fetch_bundle_t load_data,
    input  logic          unload,
    input  logic          clear,
    output logic          full,
    output fetch_bundle_t data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0};
        end else if (clear || unload) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            data <= load_data;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, runs one word fetch at a time over req/gnt/rvalid and hands
// {instr, pc, pc+4} to decode, absorbing decode stalls and execute-stage redirects.
module instr_fetch_stage
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    input  logic                   id_ready,
    output logic                   id_valid,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [ADDR_WIDTH-1:0]  id_pc,
    output logic [ADDR_WIDTH-1:0]  id_pc_plus4,
    output fetch_state_e           dbg_state
);

    // Handshakes: imem_req stays high until a cycle with imem_gnt, and imem_rvalid is never
    // stalled. A decode transfer happens on an edge with id_valid && id_ready; until then
    // id_valid and the id_* bundle stay stable unless a redirect squashes them.

    fetch_state_e          state, state_d;
    logic [ADDR_WIDTH-1:0] pc, inflight_pc;
    fetch_bundle_t         out_q, skid_data, fetched;
    logic                  do_redirect, outstanding;
    logic                  load_out, load_skid, unload_skid, pc_inc, take_gnt, skid_full;

    assign do_redirect = redirect && (state != IDLE);
    assign fetched     = {imem_rdata, inflight_pc, inflight_pc + ADDR_WIDTH'(4)};

    assign imem_req    = (state == REQ);
    assign imem_addr   = pc;
    assign id_instr    = out_q.instr;
    assign id_pc       = out_q.pc;
    assign id_pc_plus4 = out_q.pc_plus4;
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d     = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        unload_skid = 1'b0;
        pc_inc      = 1'b0;
        take_gnt    = 1'b0;
        outstanding = 1'b0;
        unique case (state)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_gnt) begin
                    take_gnt = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    pc_inc = 1'b1;
                    if (!id_valid || id_ready) begin
                        load_out = 1'b1;
                        state_d  = REQ;
                    end else begin
                        load_skid = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                // An empty skid here cannot normally happen; leaving HOLD keeps fetch alive.
                if (id_ready || !skid_full) begin
                    unload_skid = skid_full;
                    state_d     = REQ;
                end
            end
            DRAIN: begin
                if (imem_rvalid) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
        // A redirect squashes everything; DRAIN absorbs the response of a fetch still in flight.
        if (do_redirect) begin
            load_out    = 1'b0;
            load_skid   = 1'b0;
            unload_skid = 1'b0;
            pc_inc      = 1'b0;
            outstanding = (state == REQ   &&  imem_gnt)    ||
                          (state == WAIT  && !imem_rvalid) ||
                          (state == DRAIN && !imem_rvalid);
            state_d     = outstanding ? DRAIN : REQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight_pc <= RESET_PC;
            out_q       <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0};
            id_valid    <= 1'b0;
        end else begin
            if (do_redirect)  pc <= redirect_pc & ~ADDR_WIDTH'(3);
            else if (pc_inc)  pc <= pc + ADDR_WIDTH'(4);

            if (take_gnt) inflight_pc <= pc;

            if (load_out)         out_q <= fetched;
            else if (unload_skid) out_q <= skid_data;

            if (do_redirect)                    id_valid <= 1'b0;
            else if (load_out || unload_skid)   id_valid <= 1'b1;
            else if (id_ready)                  id_valid <= 1'b0;
        end
    end

    fetch_skid_buffer u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_skid),
        .load_data (fetched),
        .unload    (unload_skid),
        .clear     (do_redirect),
        .full      (skid_full),
        .data      (skid_data)
    );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: memory responder, program-order scoreboard, directed and random tests.
module tb_instr_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] STALE    = 32'hDEAD_BEEF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_gnt = 1'b0;
    logic         imem_rvalid = 1'b0;
    logic [31:0]  imem_rdata = '0;
    logic         redirect = 1'b0;
    logic [31:0]  redirect_pc = '0;
    logic         id_ready = 1'b1;
    logic         id_valid;
    logic [31:0]  id_instr, id_pc, id_pc_plus4;
    fetch_state_e dbg_state;

    instr_fetch_stage #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .dbg_state   (dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_xfer = 0;
    bit stale_seen = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[29:2], 4'h7};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_err++;
        $display("FAIL timeout_%s: got no event expected one within 200 cycles (t=%0t)", tag, $time);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_state(input fetch_state_e s, input string tag);
        for (int i = 0; i < 200; i++) begin
            if (dbg_state == s) return;
            step();
        end
        timeout(tag);
    endtask

    task automatic wait_sig(input bit want_valid, input string tag);
        for (int i = 0; i < 200; i++) begin
            if ((want_valid ? id_valid : imem_req) == 1'b1) return;
            step();
        end
        timeout(tag);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        redirect = 1'b0;
        repeat (2) step();
        check("rst_id_valid", 32'(id_valid), 0);
        check("rst_id_instr", id_instr, NOP_INSTR);
        check("rst_id_pc", id_pc, 0);
        check("rst_id_pc_plus4", id_pc_plus4, 0);
        check("rst_imem_req", 32'(imem_req), 0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
    endtask

    // ---------------- memory responder ----------------
    int gnt_pct = 100;
    int lat_min = 1;
    int lat_max = 1;
    bit mem_auto = 1'b1;
    bit poison_arm = 1'b0;
    bit pend = 1'b0;
    bit pend_poison = 1'b0;
    int pend_cnt = 0;
    logic [31:0] gnt_addr = '0;
    logic [31:0] pend_addr = '0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!mem_auto) begin
                pend = 1'b0;
                continue;
            end
            if (!rst_n) begin
                pend = 1'b0;
                imem_gnt = 1'b0;
                imem_rvalid = 1'b0;
                continue;
            end
            imem_rvalid = 1'b0;
            if (imem_gnt) begin
                pend = 1'b1;
                pend_cnt = $urandom_range(lat_min, lat_max);
                pend_addr = gnt_addr;
                pend_poison = poison_arm;
            end
            imem_gnt = 1'b0;
            if (pend) begin
                check("one_outstanding", 32'(imem_req), 0);
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata = pend_poison ? STALE : mem_word(pend_addr);
                    pend = 1'b0;
                end
            end else if (imem_req && $urandom_range(1, 100) <= gnt_pct) begin
                imem_gnt = 1'b1;
                gnt_addr = imem_addr;
            end
        end
    end

    // ---------------- scoreboard: program-order reference model ----------------
    logic [31:0] exp_pc = RESET_PC;
    bit rd_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc = RESET_PC;
            rd_prev = 1'b0;
        end else begin
            if (rd_prev) check("valid_after_redirect", 32'(id_valid), 0);
            if (id_valid && id_instr == STALE) stale_seen = 1'b1;
            if (id_valid && id_ready) begin
                check("xfer_pc", id_pc, exp_pc);
                check("xfer_pc_plus4", id_pc_plus4, exp_pc + 32'd4);
                check("xfer_instr", id_instr, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_xfer++;
            end
            rd_prev = redirect;
            if (redirect) exp_pc = redirect_pc & ~32'h3;
        end
    end

    // ---------------- tests ----------------
    typedef struct {
        logic [31:0] target;
        bit          in_req;
        int          lat;
        logic [31:0] exp_pc;
        logic [31:0] exp_plus4;
    } redir_vec_t;

    redir_vec_t  vecs[5];
    logic [31:0] exp_q[$];

    initial begin
        int xfer_base;
        vecs[0] = '{target: 32'h0000_0103, in_req: 1'b0, lat: 3, exp_pc: 32'h0000_0100, exp_plus4: 32'h0000_0104};
        vecs[1] = '{target: 32'h0000_0200, in_req: 1'b1, lat: 2, exp_pc: 32'h0000_0200, exp_plus4: 32'h0000_0204};
        vecs[2] = '{target: 32'hFFFF_FFFE, in_req: 1'b0, lat: 3, exp_pc: 32'hFFFF_FFFC, exp_plus4: 32'h0000_0000};
        vecs[3] = '{target: 32'h7FFF_FFFD, in_req: 1'b1, lat: 2, exp_pc: 32'h7FFF_FFFC, exp_plus4: 32'h8000_0000};
        vecs[4] = '{target: 32'hFFFF_FFFF, in_req: 1'b1, lat: 1, exp_pc: 32'hFFFF_FFFC, exp_plus4: 32'h0000_0000};

        // Test 1: back-to-back fetch, one instruction every 2 cycles.
        id_ready = 1'b1;
        reset_dut();
        step();
        check("idle_to_req", 32'(dbg_state), 32'(REQ));
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        wait_sig(1'b1, "t1_first");
        for (int i = 0; i < 3; i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("t1_id_pc", id_pc, e);
            check("t1_id_pc_plus4", id_pc_plus4, e + 32'd4);
            check("t1_id_valid", 32'(id_valid), 1);
            step();
            check("t1_gap", 32'(id_valid), 0);
            step();
        end

        // Test 2: decode stall for 6 cycles fills the skid.
        id_ready = 1'b0;
        reset_dut();
        wait_sig(1'b1, "t2_first");
        check("t2_first_pc", id_pc, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("t2_hold_valid", 32'(id_valid), 1);
            check("t2_hold_pc", id_pc, 32'h0);
            check("t2_hold_instr", id_instr, mem_word(32'h0));
        end
        check("t2_req_off", 32'(imem_req), 0);
        check("t2_state_hold", 32'(dbg_state), 32'(HOLD));
        id_ready = 1'b1;
        step();
        check("t2_skid_valid", 32'(id_valid), 1);
        check("t2_skid_pc", id_pc, 32'h4);
        repeat (8) step();

        // Tests 3-5: redirects in WAIT and in REQ with a same-cycle grant, including wrap.
        for (int v = 0; v < 5; v++) begin
            lat_min = vecs[v].lat;
            lat_max = vecs[v].lat;
            wait_state(REQ, "vec_req");
            if (!vecs[v].in_req) wait_state(WAIT, "vec_wait");
            redirect = 1'b1;
            redirect_pc = vecs[v].target;
            poison_arm = vecs[v].in_req;
            step();
            redirect = 1'b0;
            poison_arm = 1'b0;
            check("vec_drain", 32'(dbg_state), 32'(DRAIN));
            check("vec_squash", 32'(id_valid), 0);
            wait_sig(1'b0, "vec_refetch");
            check("vec_fetch_addr", imem_addr, vecs[v].exp_pc);
            wait_sig(1'b1, "vec_valid");
            check("vec_id_pc", id_pc, vecs[v].exp_pc);
            check("vec_id_pc_plus4", id_pc_plus4, vecs[v].exp_plus4);
            check("vec_id_instr", id_instr, mem_word(vecs[v].exp_pc));
            check("vec_next_addr", imem_addr, vecs[v].exp_plus4);
            step();
        end
        check("no_stale_directed", 32'(stale_seen), 0);

        // Test 6: reset during WAIT, then a late rvalid that must be ignored.
        mem_auto = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        reset_dut();
        wait_state(REQ, "t6_req");
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        check("t6_wait", 32'(dbg_state), 32'(WAIT));
        rst_n = 1'b0;
        step();
        check("t6_rst_valid", 32'(id_valid), 0);
        check("t6_rst_state", 32'(dbg_state), 32'(IDLE));
        step();
        rst_n = 1'b1;
        step();
        imem_rvalid = 1'b1;
        imem_rdata = STALE;
        step();
        imem_rvalid = 1'b0;
        check("t6_late_valid", 32'(id_valid), 0);
        check("t6_req", 32'(imem_req), 1);
        check("t6_addr", imem_addr, RESET_PC);
        mem_auto = 1'b1;
        wait_sig(1'b1, "t6_first");
        check("t6_first_pc", id_pc, RESET_PC);
        check("t6_first_instr", id_instr, mem_word(RESET_PC));

        // Random phase: random grants, latency, stalls and redirects.
        lat_min = 1;
        lat_max = 4;
        xfer_base = n_xfer;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) gnt_pct = $urandom_range(30, 100);
            id_ready = ($urandom_range(0, 9) < 7);
            redirect = 1'b0;
            if ($urandom_range(0, 99) < 4) begin
                redirect = 1'b1;
                if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else                           redirect_pc = $urandom;
            end
            step();
        end
        redirect = 1'b0;
        id_ready = 1'b1;
        gnt_pct = 100;
        repeat (20) step();
        check("random_progress", 32'(n_xfer - xfer_base >= 100), 1);
        check("no_stale_final", 32'(stale_seen), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
